mem_port_arbiter: RTL

Sits between the store queue, the load queue and the single data-memory port, and schedules which of them drives the port each cycle. Retired stores from the SQ are buffered in a small write buffer so retirement never waits on memory. Load misses from the LQ issue directly. Outstanding loads are tracked by memory tag so completions can be returned to the correct LQ entry. The block also blocks loads that alias a buffered store, and drops completions of loads squashed by branch recovery.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates the single data-memory port between a write
// buffer of retired stores and load-miss requests, and tracks outstanding
// loads by memory tag so completions return to the right LQ entry.
// Ports: clock/reset (sync, active-high); store_* push into the write buffer
// (wb_full/wb_empty/wb_overflow report its state); ld_req_* request a load and
// ld_req_ack reports acceptance; proc2mem_* drive the memory port and
// mem2proc_* carry the accept tag and returning data; ld_done_* is the
// registered completion to the LQ; branch_recovery squashes in-flight loads.
module mem_port_arbiter #(
  parameter int WB_DEPTH     = 4,
  parameter int DRAIN_THRESH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_recovery,
  input  logic        store_request,
  input  logic [63:0] store_retire_addr,
  input  logic [63:0] store_retire_data,
  output logic        wb_full,
  output logic        wb_empty,
  output logic        wb_overflow,
  input  logic        ld_req_valid,
  input  logic [63:0] ld_req_addr,
  input  logic [4:0]  ld_req_lq_idx,
  output logic        ld_req_ack,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        ld_done_valid,
  output logic [4:0]  ld_done_lq_idx,
  output logic [63:0] ld_done_data
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  // Write buffer
  logic [63:0] wb_addr_q [WB_DEPTH];
  logic [63:0] wb_addr_d [WB_DEPTH];
  logic [63:0] wb_data_q [WB_DEPTH];
  logic [63:0] wb_data_d [WB_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  // Outstanding-load table, indexed by memory tag (entry 0 unused)
  logic [15:0] tbl_valid_q, tbl_valid_d;
  logic [15:0] tbl_sq_q, tbl_sq_d;
  logic [4:0]  tbl_idx_q [16];
  logic [4:0]  tbl_idx_d [16];

  logic        ld_done_valid_q, ld_done_valid_d;
  logic [4:0]  ld_done_lq_idx_q, ld_done_lq_idx_d;
  logic [63:0] ld_done_data_q, ld_done_data_d;
  logic        wb_overflow_q, wb_overflow_d;

  logic hazard, store_sel, load_sel, accept, pop, push;
  logic [PW-1:0] off;

  assign wb_full  = (count_q == (PW+1)'(WB_DEPTH));
  assign wb_empty = (count_q == '0);
  assign accept   = (mem2proc_response != 4'd0);

  // A load aliases a store if they share a doubleword. Slot i is live when
  // its distance from head (mod depth) is below the occupancy.
  always_comb begin
    off    = '0;
    hazard = store_request && (store_retire_addr[63:3] == ld_req_addr[63:3]);
    for (int i = 0; i < WB_DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (wb_addr_q[i][63:3] == ld_req_addr[63:3]))
        hazard = 1'b1;
    end
  end

  assign store_sel = !wb_empty &&
                     ((count_q >= (PW+1)'(DRAIN_THRESH)) || !ld_req_valid || hazard);
  assign load_sel  = ld_req_valid && !store_sel && !hazard;
  assign pop       = store_sel && accept;
  // A full buffer still takes a push when the head leaves the same cycle.
  assign push      = store_request && (!wb_full || pop);

  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    ld_req_ack       = 1'b0;
    if (store_sel) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = wb_addr_q[head_q];
      proc2mem_data    = wb_data_q[head_q];
    end else if (load_sel) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = ld_req_addr;
      ld_req_ack       = accept;
    end
  end

  always_comb begin
    wb_addr_d        = wb_addr_q;
    wb_data_d        = wb_data_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    wb_overflow_d    = store_request && wb_full && !pop;
    tbl_valid_d      = tbl_valid_q;
    tbl_sq_d         = tbl_sq_q;
    tbl_idx_d        = tbl_idx_q;
    ld_done_valid_d  = 1'b0;
    ld_done_lq_idx_d = ld_done_lq_idx_q;
    ld_done_data_d   = ld_done_data_q;

    if (pop) head_d = head_q + 1'b1;
    if (push) begin
      wb_addr_d[tail_q] = store_retire_addr;
      wb_data_d[tail_q] = store_retire_data;
      tail_d            = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Completion reads the pre-update entry, so an allocation to the same
    // tag this cycle is applied afterwards and survives.
    if ((mem2proc_tag != 4'd0) && tbl_valid_q[mem2proc_tag]) begin
      tbl_valid_d[mem2proc_tag] = 1'b0;
      if (!tbl_sq_q[mem2proc_tag]) begin
        ld_done_valid_d  = 1'b1;
        ld_done_lq_idx_d = tbl_idx_q[mem2proc_tag];
        ld_done_data_d   = mem2proc_data;
      end
    end
    if (branch_recovery) tbl_sq_d = tbl_sq_d | tbl_valid_d;
    if (load_sel && accept) begin
      tbl_valid_d[mem2proc_response] = 1'b1;
      tbl_sq_d[mem2proc_response]    = branch_recovery;
      tbl_idx_d[mem2proc_response]   = ld_req_lq_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      tbl_valid_q      <= '0;
      tbl_sq_q         <= '0;
      ld_done_valid_q  <= 1'b0;
      ld_done_lq_idx_q <= '0;
      ld_done_data_q   <= '0;
      wb_overflow_q    <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      tbl_valid_q      <= tbl_valid_d;
      tbl_sq_q         <= tbl_sq_d;
      ld_done_valid_q  <= ld_done_valid_d;
      ld_done_lq_idx_q <= ld_done_lq_idx_d;
      ld_done_data_q   <= ld_done_data_d;
      wb_overflow_q    <= wb_overflow_d;
    end
  end

  // Payload storage needs no reset: liveness comes from count/valid.
  always_ff @(posedge clock) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
    tbl_idx_q <= tbl_idx_d;
  end

  assign ld_done_valid  = ld_done_valid_q;
  assign ld_done_lq_idx = ld_done_lq_idx_q;
  assign ld_done_data   = ld_done_data_q;
  assign wb_overflow    = wb_overflow_q;

endmodule
